// File: rtl/eeg_pea_out_arb_pkg.sv
// Shared types and defaults for the PE-array output arbiter.
// State encodings, default widths and an index-width helper.
package eeg_pea_out_arb_pkg;

    localparam int PE_NUM_DEF      = 4;
    localparam int DATA_OUT_DW_DEF = 8;
    localparam int OMUX_ADD_AW_DEF = 8;
    localparam int ORAM_ADD_AW_DEF = 10;

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_RUN   = 4'b0010,
        S_FLUSH = 4'b0100,
        S_DONE  = 4'b1000
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/eeg_rr_arb.sv
// Round-robin request picker: first set request at or above the
// pointer, wrapping modulo N; one-hot grant plus binary index.
module eeg_rr_arb #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_vld
);

    localparam int SW = IW + 1;

    logic [SW-1:0] w_sum;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_vld = 1'b0;
        w_sum = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, i_ptr} + SW'(k);
            if (w_sum >= SW'(N)) begin
                w_sum = w_sum - SW'(N);
            end
            if (!o_vld && i_req[w_sum[IW-1:0]]) begin
                o_vld                = 1'b1;
                o_gnt[w_sum[IW-1:0]] = 1'b1;
                o_idx                = w_sum[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/eeg_pea_out_arb.sv
// PE-array output arbiter: round-robin merge of PE output streams into
// one registered ORAM write port, with per-PE region relocation.
module eeg_pea_out_arb
    import eeg_pea_out_arb_pkg::*;
#(
    parameter int PE_NUM      = PE_NUM_DEF,
    parameter int DATA_OUT_DW = DATA_OUT_DW_DEF,
    parameter int OMUX_ADD_AW = OMUX_ADD_AW_DEF,
    parameter int ORAM_ADD_AW = ORAM_ADD_AW_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          CFG_START,
    input  logic [PE_NUM-1:0]             CFG_PE_ENA,
    input  logic [ORAM_ADD_AW-1:0]        CFG_OADD_STRIDE,
    output logic                          IS_IDLE,
    output logic                          DONE,
    input  logic [PE_NUM-1:0]             PE_OUT_VLD,
    input  logic [PE_NUM-1:0]             PE_OUT_LST,
    input  logic [PE_NUM*OMUX_ADD_AW-1:0] PE_OUT_ADD,
    input  logic [PE_NUM*DATA_OUT_DW-1:0] PE_OUT_DAT,
    output logic [PE_NUM-1:0]             PE_OUT_RDY,
    output logic                          ORAM_WR_VLD,
    output logic [ORAM_ADD_AW-1:0]        ORAM_WR_ADD,
    output logic [DATA_OUT_DW-1:0]        ORAM_WR_DAT,
    input  logic                          ORAM_WR_RDY
);

    localparam int IW = idx_w(PE_NUM);
    localparam int XW = (OMUX_ADD_AW > ORAM_ADD_AW) ? OMUX_ADD_AW
                                                    : ORAM_ADD_AW;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [PE_NUM-1:0]        r_ena;
    logic [PE_NUM-1:0]        r_fin;
    logic [ORAM_ADD_AW-1:0]   r_stride;
    logic [IW-1:0]            r_ptr;
    logic                     r_wr_vld;
    logic [ORAM_ADD_AW-1:0]   r_wr_add;
    logic [DATA_OUT_DW-1:0]   r_wr_dat;

    logic                     w_run;
    logic                     w_start;
    logic                     w_free;
    logic [PE_NUM-1:0]        w_req;
    logic [PE_NUM-1:0]        w_gnt;
    logic [IW-1:0]            w_idx;
    logic                     w_any;
    logic                     w_acc;
    logic [OMUX_ADD_AW-1:0]   w_ladd;
    logic [DATA_OUT_DW-1:0]   w_ldat;
    logic                     w_lst;
    logic [ORAM_ADD_AW-1:0]   w_base;
    logic [XW-1:0]            w_lx;
    logic [ORAM_ADD_AW-1:0]   w_addr;
    logic [PE_NUM-1:0]        w_fin_nxt;
    logic                     w_all_fin;
    logic [IW-1:0]            w_ptr_nxt;

    assign w_run   = (r_state == S_RUN);
    assign w_start = (r_state == S_IDLE) && CFG_START;
    assign w_free  = ~r_wr_vld | ORAM_WR_RDY;
    assign w_req   = w_run ? (r_ena & ~r_fin & PE_OUT_VLD) : '0;

    eeg_rr_arb #(
        .N  (PE_NUM),
        .IW (IW)
    ) u_rr (
        .i_req (w_req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_vld (w_any)
    );

    assign w_acc      = w_run & w_free & w_any;
    assign PE_OUT_RDY = (w_run & w_free) ? w_gnt : '0;

    // Region base is i*stride per PE, selected by the grant index
    always_comb begin
        w_ladd = '0;
        w_ldat = '0;
        w_lst  = 1'b0;
        w_base = '0;
        for (int i = 0; i < PE_NUM; i++) begin
            if (w_idx == IW'(i)) begin
                w_ladd = PE_OUT_ADD[i*OMUX_ADD_AW +: OMUX_ADD_AW];
                w_ldat = PE_OUT_DAT[i*DATA_OUT_DW +: DATA_OUT_DW];
                w_lst  = PE_OUT_LST[i];
                w_base = r_stride * ORAM_ADD_AW'(i);
            end
        end
    end

    assign w_lx      = XW'(w_ladd);
    assign w_addr    = w_base + w_lx[ORAM_ADD_AW-1:0];
    assign w_fin_nxt = r_fin | ((w_acc & w_lst) ? w_gnt : '0);
    assign w_all_fin = &(w_fin_nxt | ~r_ena);
    assign w_ptr_nxt = (w_idx == IW'(PE_NUM - 1)) ? '0
                                                  : w_idx + IW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (CFG_START) w_state_nxt = S_RUN;
            S_RUN:   if (w_all_fin) w_state_nxt = S_FLUSH;
            S_FLUSH: if (w_free)    w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ena    <= '0;
            r_fin    <= '0;
            r_stride <= '0;
            r_ptr    <= '0;
        end else if (w_start) begin
            r_ena    <= CFG_PE_ENA;
            r_fin    <= '0;
            r_stride <= CFG_OADD_STRIDE;
            r_ptr    <= '0;
        end else if (w_acc) begin
            r_fin    <= w_fin_nxt;
            r_ptr    <= w_ptr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_vld <= 1'b0;
            r_wr_add <= '0;
            r_wr_dat <= '0;
        end else if (w_acc) begin
            r_wr_vld <= 1'b1;
            r_wr_add <= w_addr;
            r_wr_dat <= w_ldat;
        end else if (ORAM_WR_RDY) begin
            r_wr_vld <= 1'b0;
        end
    end

    assign IS_IDLE     = (r_state == S_IDLE);
    assign DONE        = (r_state == S_DONE);
    assign ORAM_WR_VLD = r_wr_vld;
    assign ORAM_WR_ADD = r_wr_add;
    assign ORAM_WR_DAT = r_wr_dat;

endmodule

// File: tb/tb_eeg_pea_out_arb.sv
// Bench for eeg_pea_out_arb: queue-based reference model checked every
// cycle, plus literal expectations for each directed layer.
module tb_eeg_pea_out_arb;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int LAW = 8;
    localparam int AW  = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              CFG_START = 1'b0;
    logic [N-1:0]      CFG_PE_ENA = '0;
    logic [AW-1:0]     CFG_OADD_STRIDE = '0;
    logic              IS_IDLE;
    logic              DONE;
    logic [N-1:0]      PE_OUT_VLD = '0;
    logic [N-1:0]      PE_OUT_LST = '0;
    logic [N*LAW-1:0]  PE_OUT_ADD = '0;
    logic [N*DW-1:0]   PE_OUT_DAT = '0;
    logic [N-1:0]      PE_OUT_RDY;
    logic              ORAM_WR_VLD;
    logic [AW-1:0]     ORAM_WR_ADD;
    logic [DW-1:0]     ORAM_WR_DAT;
    logic              ORAM_WR_RDY = 1'b1;

    always #5 clk = ~clk;

    eeg_pea_out_arb #(
        .PE_NUM      (N),
        .DATA_OUT_DW (DW),
        .OMUX_ADD_AW (LAW),
        .ORAM_ADD_AW (AW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .CFG_START       (CFG_START),
        .CFG_PE_ENA      (CFG_PE_ENA),
        .CFG_OADD_STRIDE (CFG_OADD_STRIDE),
        .IS_IDLE         (IS_IDLE),
        .DONE            (DONE),
        .PE_OUT_VLD      (PE_OUT_VLD),
        .PE_OUT_LST      (PE_OUT_LST),
        .PE_OUT_ADD      (PE_OUT_ADD),
        .PE_OUT_DAT      (PE_OUT_DAT),
        .PE_OUT_RDY      (PE_OUT_RDY),
        .ORAM_WR_VLD     (ORAM_WR_VLD),
        .ORAM_WR_ADD     (ORAM_WR_ADD),
        .ORAM_WR_DAT     (ORAM_WR_DAT),
        .ORAM_WR_RDY     (ORAM_WR_RDY)
    );

    typedef struct { int a; int d; bit l; } beat_t;
    typedef struct { int a; int d; } wr_t;

    beat_t    pq[N][$];
    wr_t      mq[$];
    int       obs[$];
    int       total = 0;
    int       bad = 0;
    int       cyc = 0;
    int       m_ph = 0;
    int       m_ptr = 0;
    bit [N-1:0] m_fin = '0;
    bit [N-1:0] m_ena = '0;
    int       m_stride = 0;
    bit [N-1:0] hs = '0;
    int       hs_cnt[N];
    int       last_acc_cyc = 0;
    int       done_cyc = 0;
    int       start_cyc = 0;
    int       done_cnt = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic int pick(input bit [N-1:0] el, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (el[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // Model: IDLE=0 RUN=1 FLUSH=2 DONE=3; mq holds the pending write
    initial forever begin
        bit [N-1:0] el;
        int g;
        bit free;
        bit pre_vld;
        @(negedge clk);
        if (!rst_n) begin
            m_ph = 0;
            m_ptr = 0;
            m_fin = '0;
            mq.delete();
        end
        free = (mq.size() == 0) || ORAM_WR_RDY;
        el = (m_ph == 1) ? (m_ena & ~m_fin & PE_OUT_VLD) : '0;
        g = (free && el != '0) ? pick(el, m_ptr) : -1;
        chk("is_idle", int'(IS_IDLE), int'(m_ph == 0));
        chk("done", int'(DONE), int'(m_ph == 3));
        chk("wr_vld", int'(ORAM_WR_VLD), int'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("wr_add", int'(ORAM_WR_ADD), mq[0].a);
            chk("wr_dat", int'(ORAM_WR_DAT), mq[0].d);
        end
        chk("pe_rdy", int'(PE_OUT_RDY), (g >= 0) ? (1 << g) : 0);
        hs = PE_OUT_VLD & PE_OUT_RDY;
        for (int i = 0; i < N; i++) if (hs[i]) hs_cnt[i]++;
        if ((hs & PE_OUT_LST) != '0) last_acc_cyc = cyc;
        if (ORAM_WR_VLD && ORAM_WR_RDY) obs.push_back(int'(ORAM_WR_ADD));
        if (DONE) begin
            done_cyc = cyc;
            done_cnt++;
        end
        if (CFG_START && IS_IDLE) start_cyc = cyc;
        if (rst_n) begin
            pre_vld = (mq.size() > 0);
            if (pre_vld && ORAM_WR_RDY) void'(mq.pop_front());
            case (m_ph)
                0: if (CFG_START) begin
                    m_ph = 1;
                    m_ena = CFG_PE_ENA;
                    m_stride = int'(CFG_OADD_STRIDE);
                    m_fin = '0;
                    m_ptr = 0;
                end
                1: begin
                    if (g >= 0) begin
                        wr_t w;
                        w.a = (g * m_stride
                               + int'(PE_OUT_ADD[g*LAW +: LAW])) % (1 << AW);
                        w.d = int'(PE_OUT_DAT[g*DW +: DW]);
                        mq.push_back(w);
                        m_ptr = (g + 1) % N;
                        if (PE_OUT_LST[g]) m_fin[g] = 1'b1;
                    end
                    if ((m_fin | ~m_ena) == {N{1'b1}}) m_ph = 2;
                end
                2: if (!pre_vld || ORAM_WR_RDY) m_ph = 3;
                default: m_ph = 0;
            endcase
        end
        cyc++;
    end

    // PE stream driver: pops accepted beats, presents queue heads
    initial forever begin
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i] && pq[i].size() > 0) void'(pq[i].pop_front());
        end
        PE_OUT_VLD = '0;
        PE_OUT_LST = '0;
        PE_OUT_ADD = '0;
        PE_OUT_DAT = '0;
        for (int i = 0; i < N; i++) begin
            if (pq[i].size() > 0) begin
                PE_OUT_VLD[i] = 1'b1;
                PE_OUT_LST[i] = pq[i][0].l;
                PE_OUT_ADD[i*LAW +: LAW] = LAW'(pq[i][0].a);
                PE_OUT_DAT[i*DW +: DW] = DW'(pq[i][0].d);
            end
        end
    end

    task automatic push(input int p, input int a, input int d,
                        input bit l);
        beat_t b;
        b.a = a;
        b.d = d;
        b.l = l;
        pq[p].push_back(b);
    endtask

    task automatic start(input logic [N-1:0] m, input int s);
        obs.delete();
        for (int i = 0; i < N; i++) hs_cnt[i] = 0;
        @(posedge clk);
        #2;
        CFG_PE_ENA = m;
        CFG_OADD_STRIDE = AW'(s);
        CFG_START = 1'b1;
        @(posedge clk);
        #2;
        CFG_START = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int c0;
        int n;
        c0 = done_cnt;
        n = 0;
        while (done_cnt == c0 && n < lim) begin
            @(posedge clk);
            n++;
        end
        chk("done_seen", int'(done_cnt > c0), 1);
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic chk_obs(input string nm, input int exp[$]);
        chk({nm, "_cnt"}, obs.size(), exp.size());
        for (int i = 0; i < exp.size() && i < obs.size(); i++) begin
            chk(nm, obs[i], exp[i]);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) hs_cnt[i] = 0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_idle", int'(IS_IDLE), 1);
        chk("rst_done", int'(DONE), 0);
        chk("rst_rdy", int'(PE_OUT_RDY), 0);
        chk("rst_vld", int'(ORAM_WR_VLD), 0);
        chk("rst_add", int'(ORAM_WR_ADD), 0);
        chk("rst_dat", int'(ORAM_WR_DAT), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        push(0, 0, 5, 0);
        push(0, 1, 6, 0);
        push(0, 2, 7, 1);
        start(4'b0001, 256);
        wait_done(50);
        chk_obs("t1_add", '{0, 1, 2});
        chk("t1_done_lat", done_cyc - last_acc_cyc, 2);

        for (int i = 0; i < N; i++) begin
            push(i, 3, 10 + i, 0);
            push(i, 4, 20 + i, 1);
        end
        start(4'b1111, 100);
        wait_done(50);
        chk_obs("t2_add", '{3, 103, 203, 303, 4, 104, 204, 304});

        for (int i = 0; i < N; i++) begin
            push(i, 3, 30 + i, 0);
            push(i, 4, 40 + i, 1);
        end
        start(4'b1111, 100);
        repeat (2) @(posedge clk);
        #2 ORAM_WR_RDY = 1'b0;
        repeat (5) @(posedge clk);
        #2 ORAM_WR_RDY = 1'b1;
        wait_done(50);
        chk_obs("t3_add", '{3, 103, 203, 303, 4, 104, 204, 304});

        push(0, 1, 40, 0);
        push(0, 2, 41, 1);
        push(2, 5, 42, 1);
        for (int k = 0; k < 6; k++) push(1, 9, 99, 0);
        start(4'b0101, 16);
        CFG_PE_ENA = 4'b1111;
        CFG_OADD_STRIDE = '0;
        CFG_START = 1'b1;
        @(posedge clk);
        #2 CFG_START = 1'b0;
        wait_done(50);
        chk_obs("t4_add", '{1, 37, 2});
        chk("t4_pe1_acc", hs_cnt[1], 0);
        pq[1].delete();
        repeat (2) @(posedge clk);
        #2;

        start(4'b0000, 77);
        wait_done(20);
        chk("t5_writes", obs.size(), 0);
        chk("t5_done_lat", done_cyc - start_cyc, 3);

        push(0, 6, 50, 1);
        push(1, 7, 51, 1);
        ORAM_WR_RDY = 1'b0;
        start(4'b0011, 8);
        repeat (2) @(posedge clk);
        #2;
        chk("t6_pre_vld", int'(ORAM_WR_VLD), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_vld", int'(ORAM_WR_VLD), 0);
        chk("t6_rst_add", int'(ORAM_WR_ADD), 0);
        chk("t6_rst_idle", int'(IS_IDLE), 1);
        chk("t6_rst_rdy", int'(PE_OUT_RDY), 0);
        for (int i = 0; i < N; i++) pq[i].delete();
        ORAM_WR_RDY = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        push(1, 7, 60, 0);
        push(1, 8, 61, 1);
        start(4'b0010, 256);
        wait_done(50);
        chk_obs("t6_add", '{263, 264});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
